// File: rtl/pilot_doubler_38khz.sv
// -----------------------------------------------------------------------------
// pilot_doubler_38khz
//
// Builds the 38kHz stereo subcarrier from the 19kHz pilot. Each pilot sample is
// squared, the DC term is removed by a leaky tracker, and the AC remainder is
// inverted, gained up and saturated to 16 bits. The result is -cos(2wt). The DC
// estimate is also reported as pilot_level and drives a hysteretic
// stereo_detect flag.
//
// Handshake: in_tick is a one-cycle strobe qualifying xin. It is accepted
// only while the FSM is IDLE; a strobe in any other state is dropped. Each
// accepted sample produces exactly one out_tick, a one-cycle strobe. That strobe
// is high in the cycle after the fourth edge following acceptance.
// carrier_out, pilot_level and stereo_detect hold their values between
// out_ticks. There is no backpressure.
//
// Ports
//   CLK            in   1   system clock
//   RST            in   1   synchronous reset, active-high
//   xin            in   16  signed pilot sample, valid with in_tick
//   in_tick        in   1   new-sample strobe
//   carrier_out    out  16  signed 38kHz carrier sample
//   out_tick       out  1   carrier_out updated strobe
//   stereo_detect  out  1   pilot present (hysteretic)
//   pilot_level    out  16  dc estimate, saturated unsigned
//   fsm_state      out  3   current FSM state (IDLE=0 .. OUT=4)
// -----------------------------------------------------------------------------
module pilot_doubler_38khz #(
  parameter int DC_SHIFT   = 8,
  parameter int GAIN_SHIFT = 2,
  parameter int DET_THRESH = 256,
  parameter int DET_HOLD   = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] xin,
  input  logic               in_tick,
  output logic signed [15:0] carrier_out,
  output logic               out_tick,
  output logic               stereo_detect,
  output logic        [15:0] pilot_level,
  output logic        [2:0]  fsm_state
);

  localparam int ACC_W = 17 + DC_SHIFT;
  // ac is 18 bits; the gain shift plus one bit of headroom for the negation.
  localparam int T_W   = 18 + GAIN_SHIFT + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    DC     = 3'd2,
    SCALE  = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t                   state;
  logic signed [15:0]       x_q;
  logic        [16:0]       sq17_q;
  logic        [16:0]       dc_q;
  logic signed [17:0]       ac_q;
  logic        [ACC_W-1:0]  dc_acc;
  logic        [10:0]       cnt;

  assign fsm_state = state;

  // Square. Only the top 17 bits are kept, so -32768 squared gives 32768.
  logic signed [31:0] x_ext;
  logic signed [31:0] sq_full;
  assign x_ext   = 32'(x_q);
  assign sq_full = x_ext * x_ext;

  logic unused_sq_low;
  assign unused_sq_low = ^sq_full[14:0];

  // DC tracker. dc_now never exceeds dc_acc, so the accumulator cannot go
  // negative.
  logic        [16:0]      dc_now;
  logic signed [17:0]      ac_now;
  logic        [ACC_W-1:0] dc_acc_next;
  assign dc_now      = dc_acc[ACC_W-1:DC_SHIFT];
  assign ac_now      = $signed({1'b0, sq17_q}) - $signed({1'b0, dc_now});
  assign dc_acc_next = dc_acc + ACC_W'(sq17_q) - ACC_W'(dc_now);

  // Inversion gives -cos(2wt). The negation happens at full width before the clamp.
  logic signed [T_W-1:0] t_full;
  logic signed [15:0]    t_sat;
  assign t_full = -($signed({{(GAIN_SHIFT + 1){ac_q[17]}}, ac_q}) <<< GAIN_SHIFT);

  always_comb begin
    t_sat = t_full[15:0];
    if (!t_full[T_W-1] && (|t_full[T_W-2:15]))
      t_sat = 16'sh7FFF;
    else if (t_full[T_W-1] && !(&t_full[T_W-2:15]))
      t_sat = -16'sh8000;
  end

  logic [15:0] level_now;
  assign level_now = dc_q[16] ? 16'hFFFF : dc_q[15:0];

  // Detector qualifier depends on the current state. The band between
  // DET_THRESH/2 and DET_THRESH qualifies in neither direction.
  logic        qual;
  logic [10:0] cnt_inc;
  assign qual    = stereo_detect ? (dc_q < 17'(DET_THRESH / 2))
                                 : (dc_q >= 17'(DET_THRESH));
  assign cnt_inc = cnt + 11'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      x_q           <= '0;
      sq17_q        <= '0;
      dc_q          <= '0;
      ac_q          <= '0;
      dc_acc        <= '0;
      cnt           <= '0;
      carrier_out   <= '0;
      out_tick      <= 1'b0;
      stereo_detect <= 1'b0;
      pilot_level   <= '0;
    end else begin
      out_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (in_tick) begin
            x_q   <= xin;
            state <= SQUARE;
          end
        end
        SQUARE: begin
          sq17_q <= sq_full[31:15];
          state  <= DC;
        end
        DC: begin
          dc_q   <= dc_now;
          ac_q   <= ac_now;
          dc_acc <= dc_acc_next;
          state  <= SCALE;
        end
        SCALE: begin
          carrier_out <= t_sat;
          pilot_level <= level_now;
          // The DET_HOLD-th consecutive qualifying sample flips the flag.
          if (qual) begin
            if (cnt_inc == 11'(DET_HOLD)) begin
              stereo_detect <= ~stereo_detect;
              cnt           <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= '0;
          end
          state <= OUT;
        end
        OUT: begin
          out_tick <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
